axi_mem_resp: RTL

//  Responder (memory end) for the address/data/response handshake used by the DMA-style ctrl initiator.

---
 rtl/axi_mem_resp_if.sv | 47 ++++
 rtl/axi_mem_resp.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_resp_if.sv
// Address/data/response handshake bundle between the ctrl initiator (master)
// and the memory responder (slave). AXI_RESP_ERR_EN adds the 2-bit response
// codes that travel with read data and the write response.
interface axi_mem_resp_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    i_rd_addr_vld;
   logic [ADDR_WIDTH-1:0]   i_rd_addr;
   logic                    o_rd_addr_rdy;
   logic                    o_rd_data_vld;
   logic [DATA_WIDTH-1:0]   o_rd_data;
   logic                    i_rd_data_rdy;
   logic                    i_wr_addr_vld;
   logic [ADDR_WIDTH-1:0]   i_wr_addr;
   logic                    o_wr_addr_rdy;
   logic                    i_wr_data_vld;
   logic [DATA_WIDTH-1:0]   i_wr_data;
   logic [DATA_WIDTH/8-1:0] i_wr_strb;
   logic                    o_wr_data_rdy;
   logic                    o_wr_resp_vld;
   logic                    i_wr_resp_rdy;
`ifdef AXI_RESP_ERR_EN
   logic [1:0]              o_rd_resp;
   logic [1:0]              o_wr_resp;
`endif

   modport slave (
      input  i_rd_addr_vld, i_rd_addr, i_rd_data_rdy,
      input  i_wr_addr_vld, i_wr_addr, i_wr_data_vld, i_wr_data, i_wr_strb, i_wr_resp_rdy,
`ifdef AXI_RESP_ERR_EN
      output o_rd_resp, o_wr_resp,
`endif
      output o_rd_addr_rdy, o_rd_data_vld, o_rd_data,
      output o_wr_addr_rdy, o_wr_data_rdy, o_wr_resp_vld
   );

   modport master (
      output i_rd_addr_vld, i_rd_addr, i_rd_data_rdy,
      output i_wr_addr_vld, i_wr_addr, i_wr_data_vld, i_wr_data, i_wr_strb, i_wr_resp_rdy,
`ifdef AXI_RESP_ERR_EN
      input  o_rd_resp, o_wr_resp,
`endif
      input  o_rd_addr_rdy, o_rd_data_vld, o_rd_data,
      input  o_wr_addr_rdy, o_wr_data_rdy, o_wr_resp_vld
   );
endinterface

// File: rtl/axi_mem_resp.sv
// Memory-end responder: DEPTH x DATA_WIDTH word store serving reads through a
// one-entry output register and writes through an address/data holding FSM.
// Optional macro AXI_RESP_ERR_EN: out-of-range accesses return response 2'b10
// (reads give zero data, writes leave memory untouched); without it the word
// index is simply truncated and every write commits.
module axi_mem_resp #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 2048,
   parameter int                    ADDR_SHIFT = 2,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input logic           clk,
   input logic           rst_n,
   axi_mem_resp_if.slave bus
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int STRB_W = DATA_WIDTH / 8;

   // State encoding mirrors {aw_held, w_held}
   typedef enum logic [1:0] {
      WR_EMPTY = 2'b00,
      WR_DATA  = 2'b01,
      WR_ADDR  = 2'b10,
      WR_BOTH  = 2'b11
   } wr_state_t;

   // Modulo-2^ADDR_WIDTH offset, then truncated to the memory index
   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> ADDR_SHIFT);
   endfunction

`ifdef AXI_RESP_ERR_EN
   function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
      return (a < BASE_ADDR) || (((a - BASE_ADDR) >> ADDR_SHIFT) >= ADDR_WIDTH'(DEPTH));
   endfunction
`endif

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // ---------------- read path ----------------
   logic                  rd_vld_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  ar_rdy, ar_fire, rd_fire;

   assign ar_rdy  = !rd_vld_q || bus.i_rd_data_rdy;
   assign ar_fire = bus.i_rd_addr_vld && ar_rdy;
   assign rd_fire = rd_vld_q && bus.i_rd_data_rdy;

`ifdef AXI_RESP_ERR_EN
   logic [1:0] rd_resp_q;
   logic       rd_oob;
   assign rd_oob = out_of_range(bus.i_rd_addr);

   // Read output register; sees memory before any same-edge commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
         rd_resp_q <= 2'b00;
      end else if (ar_fire) begin
         rd_vld_q  <= 1'b1;
         rd_data_q <= rd_oob ? '0 : mem[word_idx(bus.i_rd_addr)];
         rd_resp_q <= rd_oob ? 2'b10 : 2'b00;
      end else if (rd_fire) begin
         rd_vld_q  <= 1'b0;
      end
   end
   assign bus.o_rd_resp = rd_resp_q;
`else
   // Read output register; sees memory before any same-edge commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else if (ar_fire) begin
         rd_vld_q  <= 1'b1;
         rd_data_q <= mem[word_idx(bus.i_rd_addr)];
      end else if (rd_fire) begin
         rd_vld_q  <= 1'b0;
      end
   end
`endif

   assign bus.o_rd_addr_rdy = ar_rdy;
   assign bus.o_rd_data_vld = rd_vld_q;
   assign bus.o_rd_data     = rd_data_q;

   // ---------------- write path ----------------
   wr_state_t             wr_state, wr_state_n;
   logic                  aw_held, w_held;
   logic                  aw_rdy, w_rdy, aw_fire, w_fire, commit, wr_en;
   logic                  resp_vld_q;
   logic [IDX_W-1:0]      aw_idx_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;

   assign aw_held = (wr_state == WR_ADDR) || (wr_state == WR_BOTH);
   assign w_held  = (wr_state == WR_DATA) || (wr_state == WR_BOTH);

   // Write FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_state <= WR_EMPTY;
      else        wr_state <= wr_state_n;
   end

   // Commit/ready decode and next state; a commit frees both holders so a new
   // pair can be captured on the same edge
   always_comb begin
      commit     = (wr_state == WR_BOTH) && (!resp_vld_q || bus.i_wr_resp_rdy);
      aw_rdy     = !aw_held || commit;
      w_rdy      = !w_held || commit;
      aw_fire    = bus.i_wr_addr_vld && aw_rdy;
      w_fire     = bus.i_wr_data_vld && w_rdy;
      wr_state_n = wr_state;
      unique case (wr_state)
         WR_EMPTY: wr_state_n = wr_state_t'({aw_fire, w_fire});
         WR_ADDR:  if (w_fire)  wr_state_n = WR_BOTH;
         WR_DATA:  if (aw_fire) wr_state_n = WR_BOTH;
         WR_BOTH:  if (commit)  wr_state_n = wr_state_t'({aw_fire, w_fire});
      endcase
   end

   assign bus.o_wr_addr_rdy = aw_rdy;
   assign bus.o_wr_data_rdy = w_rdy;

`ifdef AXI_RESP_ERR_EN
   logic       aw_oob_q;
   logic [1:0] wr_resp_q;
   assign wr_en = commit && !aw_oob_q;

   // Address holder, remembering whether the target is outside the memory
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_idx_q <= '0;
         aw_oob_q <= 1'b0;
      end else if (aw_fire) begin
         aw_idx_q <= word_idx(bus.i_wr_addr);
         aw_oob_q <= out_of_range(bus.i_wr_addr);
      end
   end

   // Write response register with its code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_vld_q <= 1'b0;
         wr_resp_q  <= 2'b00;
      end else if (commit) begin
         resp_vld_q <= 1'b1;
         wr_resp_q  <= aw_oob_q ? 2'b10 : 2'b00;
      end else if (resp_vld_q && bus.i_wr_resp_rdy) begin
         resp_vld_q <= 1'b0;
      end
   end
   assign bus.o_wr_resp = wr_resp_q;
`else
   assign wr_en = commit;

   // Address holder
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       aw_idx_q <= '0;
      else if (aw_fire) aw_idx_q <= word_idx(bus.i_wr_addr);
   end

   // Write response register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  resp_vld_q <= 1'b0;
      else if (commit)                             resp_vld_q <= 1'b1;
      else if (resp_vld_q && bus.i_wr_resp_rdy)    resp_vld_q <= 1'b0;
   end
`endif

   assign bus.o_wr_resp_vld = resp_vld_q;

   // Data/strobe holder
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_data_q <= '0;
         w_strb_q <= '0;
      end else if (w_fire) begin
         w_data_q <= bus.i_wr_data;
         w_strb_q <= bus.i_wr_strb;
      end
   end

   // Byte-masked memory update on commit; storage itself is never reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < STRB_W; k++) begin
            if (w_strb_q[k]) mem[aw_idx_q][8*k +: 8] <= w_data_q[8*k +: 8];
         end
      end
   end

endmodule
